serial_addsub15: RTL

SERIAL_ADDSUB15 -- requirements
Module: serial_addsub15

---
 rtl/addsub_pkg.sv | 19 +
 rtl/serial_fa.sv | 13 +
 rtl/serial_addsub15.sv | 94 +++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared width, counter sizing and FSM encoding for the bit-serial adder/subtractor.
package addsub_pkg;

  localparam int WIDTH = 15;

  // Counter must hold 0..WIDTH
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa.sv
// Single combinational full-adder cell shared by every bit position.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub15.sv
// Bit-serial two's complement add/subtract: one bit per clock, LSB first,
// one full-adder cell plus a carry flop; all outputs registered.
module serial_addsub15 #(
  parameter int WIDTH = addsub_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  import addsub_pkg::*;

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  serial_fa u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtract as A + ~B + 1: invert B now, inject the +1 via the carry flop
            sh_a  <= a;
            sh_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          acc   <= {fa_s, acc[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB here
            result <= {fa_s, acc[WIDTH-1:1]};
            cout   <= fa_co;
            ovf    <= carry ^ fa_co;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
